// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and field-split stage for a single-cycle MIPS execute block.
// Latency: 3 cycles minimum per instruction (REQ -> WAIT -> EXEC); each not-ready, late-rvalid or stall cycle adds one.
// Backpressure: imem_req is held with a stable address until imem_ready; stall holds the instruction in EXEC.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   -> a misaligned pc_next at retirement raises a sticky fault and parks the FSM in FAULT
//   undefined -> pc_next is force-aligned, fault is tied 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr            fetch request and address (address = pc)
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid/rdata        returned instruction word, only honoured in WAIT
//   pc, pc_next              architectural PC out, next PC from execute block in
//   stall                    downstream hold of the current instruction
//   exec_valid               instruction register valid for the execute window
//   opcode .. jtype_addres   pure slices of the instruction register
//   retire_count             retired instructions since reset (wraps)
//   fault                    sticky misaligned-PC fault
module fetch_unit #(
  parameter int                   WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  output logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] pc_next,
  input  logic                 stall,
  output logic                 exec_valid,
  output logic [5:0]           opcode,
  output logic [4:0]           rtype_rs,
  output logic [4:0]           rtype_rt,
  output logic [4:0]           rtype_rd,
  output logic [4:0]           rtype_shamt,
  output logic [5:0]           rtype_funct,
  output logic [4:0]           itype_rs,
  output logic [4:0]           itype_rt,
  output logic [15:0]          itype_immediate,
  output logic [25:0]          jtype_addres,
  output logic [31:0]          retire_count,
  output logic                 fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

  state_t               state;
  state_t               state_nxt;
  logic [WORD_SIZE-1:0] pc_q;
  logic [31:0]          ir;
  logic [31:0]          count_q;
  logic                 retire;
  logic                 misalign;

  assign retire = (state == S_EXEC) && !stall;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign misalign = (pc_next[1:0] != 2'b00);
  assign fault    = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (retire && misalign) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
  assign fault    = 1'b0;
`endif

  // Next-state logic; outputs are decoded directly from the registered state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (imem_ready) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_nxt = S_EXEC;
      S_EXEC:  if (retire) state_nxt = misalign ? S_FAULT : S_REQ;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      ir      <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state <= state_nxt;
      // rvalid outside WAIT belongs to an abandoned fetch and is dropped.
      if ((state == S_WAIT) && imem_rvalid) begin
        ir <= imem_rdata;
      end
      if (retire) begin
        count_q <= count_q + 32'd1;
        // A faulting retirement still counts but leaves the PC where it was.
        if (!misalign) begin
          pc_q <= pc_next & ALIGN_MASK;
        end
      end
    end
  end

  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign exec_valid = (state == S_EXEC);
  assign retire_count = count_q;

  assign opcode          = ir[31:26];
  assign rtype_rs        = ir[25:21];
  assign rtype_rt        = ir[20:16];
  assign rtype_rd        = ir[15:11];
  assign rtype_shamt     = ir[10:6];
  assign rtype_funct     = ir[5:0];
  assign itype_rs        = ir[25:21];
  assign itype_rt        = ir[20:16];
  assign itype_immediate = ir[15:0];
  assign jtype_addres    = ir[25:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed literal checks followed by randomized traffic against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        stall;
  logic        exec_valid;
  logic [5:0]  opcode;
  logic [4:0]  rtype_rs, rtype_rt, rtype_rd, rtype_shamt, itype_rs, itype_rt;
  logic [5:0]  rtype_funct;
  logic [15:0] itype_immediate;
  logic [25:0] jtype_addres;
  logic [31:0] retire_count;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.WORD_SIZE(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .pc_next(pc_next), .stall(stall), .exec_valid(exec_valid),
    .opcode(opcode), .rtype_rs(rtype_rs), .rtype_rt(rtype_rt), .rtype_rd(rtype_rd),
    .rtype_shamt(rtype_shamt), .rtype_funct(rtype_funct),
    .itype_rs(itype_rs), .itype_rt(itype_rt), .itype_immediate(itype_immediate),
    .jtype_addres(jtype_addres), .retire_count(retire_count), .fault(fault)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: where the current instruction is in its life, plus architectural state.
  localparam int P_IDLE = 0, P_ASK = 1, P_AWAIT = 2, P_RUN = 3, P_DEAD = 4;
  int          m_ph = P_IDLE;
  logic [31:0] m_pc = RV;
  logic [31:0] m_ir = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  bit          m_fault = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_pc = RV; m_ir = 32'd0; m_cnt = 32'd0; m_fault = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE:  m_ph = P_ASK;
        P_ASK:   if (imem_ready) m_ph = P_AWAIT;
        P_AWAIT: if (imem_rvalid) begin m_ir = imem_rdata; m_ph = P_RUN; end
        P_RUN: if (!stall) begin
          m_cnt = m_cnt + 32'd1;
          if (ALIGN && (pc_next % 32'd4) != 32'd0) begin
            m_fault = 1'b1;
            m_ph = P_DEAD;
          end else begin
            m_pc = pc_next - (pc_next % 32'd4);
            m_ph = P_ASK;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pc", pc, m_pc);
      check("m_req", imem_req, (m_ph == P_ASK));
      if (m_ph == P_ASK) check("m_addr", imem_addr, m_pc);
      check("m_exec", exec_valid, (m_ph == P_RUN));
      check("m_count", retire_count, m_cnt);
      check("m_fault", fault, m_fault);
      check("m_opcode", opcode, m_ir >> 26);
      check("m_rs", rtype_rs, (m_ir >> 21) % 32);
      check("m_rt", itype_rt, (m_ir >> 16) % 32);
      check("m_rd", rtype_rd, (m_ir >> 11) % 32);
      check("m_shamt", rtype_shamt, (m_ir >> 6) % 32);
      check("m_funct", rtype_funct, m_ir % 64);
      check("m_imm", itype_immediate, m_ir % 65536);
      check("m_jaddr", jtype_addres, m_ir % 32'h0400_0000);
      check("m_irs", itype_rs, rtype_rs);
      check("m_irt", rtype_rt, (m_ir >> 16) % 32);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b1; stall = 1'b0;
    imem_rdata = 32'h012A_4020; pc_next = 32'h4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pc", pc, RV);
    check("rst_req", imem_req, 0);
    check("rst_exec", exec_valid, 0);
    check("rst_count", retire_count, 0);
    check("rst_fault", fault, 0);
    check("rst_jaddr", jtype_addres, 0);

    // Zero-wait fetch of add $t0,$t1,$t2.
    rst = 1'b0;
    step();
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, 32'h0);
    step();
    check("wait_req", imem_req, 0);
    check("wait_exec", exec_valid, 0);
    step();
    check("ex_valid", exec_valid, 1);
    check("ex_opcode", opcode, 0);
    check("ex_rs", rtype_rs, 9);
    check("ex_rt", rtype_rt, 10);
    check("ex_rd", rtype_rd, 8);
    check("ex_funct", rtype_funct, 6'h20);
    step();
    check("ret_exec", exec_valid, 0);
    check("ret_req", imem_req, 1);
    check("ret_addr", imem_addr, 32'h4);
    check("ret_count", retire_count, 1);

    // Memory not ready for 3 cycles: request held 4 cycles at constant address.
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h8D28_0004;
    for (int i = 0; i < 4; i++) begin
      check("hold_req", imem_req, 1);
      check("hold_addr", imem_addr, 32'h4);
      if (i == 3) imem_ready = 1'b1;
      step();
    end
    check("hold_wait_req", imem_req, 0);
    step();
    check("late_rv_req", imem_req, 0);
    check("late_rv_exec", exec_valid, 0);
    imem_rvalid = 1'b1;
    step();

    // Stall for 5 cycles: 6 cycles of a constant execute window.
    stall = 1'b1; imem_rvalid = 1'b0; pc_next = 32'h8;
    for (int i = 0; i < 6; i++) begin
      check("stall_exec", exec_valid, 1);
      check("stall_opcode", opcode, 6'h23);
      check("stall_rs", itype_rs, 9);
      check("stall_rt", itype_rt, 8);
      check("stall_imm", itype_immediate, 16'h4);
      check("stall_pc", pc, 32'h4);
      check("stall_req", imem_req, 0);
      if (i == 5) stall = 1'b0;
      step();
    end
    check("unstall_addr", imem_addr, 32'h8);
    check("unstall_count", retire_count, 2);

    // Reset during WAIT, then a stale rvalid.
    step();
    check("rw_wait_req", imem_req, 0);
    rst = 1'b1; imem_ready = 1'b0;
    step();
    check("rw_pc", pc, RV);
    check("rw_count", retire_count, 0);
    rst = 1'b0; imem_rvalid = 1'b1;
    step();
    check("stale_exec0", exec_valid, 0);
    step();
    check("stale_exec1", exec_valid, 0);
    check("stale_pc", pc, RV);
    check("stale_req", imem_req, 1);

    // Misaligned pc_next at retirement.
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h012A_4020; pc_next = 32'h0000_1002;
    step();
    imem_rvalid = 1'b1;
    step();
    check("mis_exec", exec_valid, 1);
    imem_rvalid = 1'b0;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_fault", fault, 1);
    check("mis_count", retire_count, 1);
    check("mis_pc", pc, RV);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_req", imem_req, 0);
      check("fault_exec", exec_valid, 0);
    end
`else
    check("mis_req", imem_req, 1);
    check("mis_addr", imem_addr, 32'h0000_1000);
    check("mis_fault", fault, 0);
`endif

    // Randomized traffic.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom % 64);
      rst         = (m_fault ? ($urandom % 10 == 0) : ($urandom % 200 == 0));
      imem_ready  = 1'($urandom % 2);
      imem_rvalid = 1'($urandom % 2);
      stall       = ($urandom % 3 == 0);
      imem_rdata  = $urandom;
      if (r == 0)      pc_next = $urandom & 32'hFFFF_FFFC;
      else if (r == 1) pc_next = 32'hFFFF_FFFC;
      else if (r == 2) pc_next = m_pc + 32'd4 + 32'($urandom_range(1, 3));
      else             pc_next = m_pc + 32'd4;
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and field-split stage feeding the single-cycle MIPS execute/decode block. It owns the architectural program counter and fetches one 32-bit instruction at a time over a request/ready/valid instruction-memory port. It holds the instruction in an instruction register and splits it into R/I/J-type fields. It presents each instruction for exactly one execute window and loads the execute block's `pc_next` into the PC when the instruction retires.

## Interface
- `WORD_SIZE`, 32, datapath and PC width.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request, held until accepted.
- `imem_addr`  out  WORD_SIZE  fetch address (= PC), stable while `imem_req`=1.
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  WORD_SIZE  current PC, to execute block.
- `pc_next`  in  WORD_SIZE  next PC computed by execute block.
- `stall`  in  1  downstream not ready; holds the current instruction in EXEC.
- `exec_valid`  out  1  instruction register valid; downstream write enables are qualified with it.
- `opcode`  out  6  instr[31:26].
- `rtype_rs`/`itype_rs`  out  5  instr[25:21].
- `rtype_rt`/`itype_rt`  out  5  instr[20:16].
- `rtype_rd`  out  5  instr[15:11].
- `rtype_shamt`  out  5  instr[10:6].
- `rtype_funct`  out  6  instr[5:0].
- `itype_immediate`  out  16  instr[15:0].
- `jtype_addres`  out  26  instr[25:0].
- `retire_count`  out  32  instructions retired since reset.
- `fault`  out  1  misaligned-PC fault, sticky (see Configuration).

## Operation
- FSM states: IDLE, REQ, WAIT, EXEC, FAULT.
- IDLE: entered on reset. Transitions to REQ on the next cycle.
- REQ: `imem_req`=1, `imem_addr`=`pc`.
  - If `imem_ready`=1, go to WAIT.
  - Otherwise stay in REQ with the address unchanged.
- WAIT: `imem_req`=0.
  - On `imem_rvalid`=1, capture `imem_rdata` into the instruction register and go to EXEC.
  - `imem_rvalid` is ignored in every state other than WAIT.
- EXEC: `exec_valid`=1. Field outputs are pure slices of the instruction register.
  - If `stall`=1, remain in EXEC; PC and instruction register unchanged.
  - If `stall`=0, retire: `pc` <= `pc_next`, `retire_count` += 1, go to REQ.
- `retire_count` wraps modulo 2^32.
- `pc_next` is taken as-is, with WORD_SIZE modulo wrap; 32'hFFFF_FFFC + 4 gives 0.
- Field outputs are driven from the instruction register in all states and are meaningful only when `exec_valid`=1.

## Timing
- Reset values:
  - `pc`=`RESET_VECTOR`, state=IDLE, instruction register=0.
  - `imem_req`=0, `exec_valid`=0, `retire_count`=0, `fault`=0.
  - All field outputs are 0.
- Minimum instruction period is 3 cycles: REQ with same-cycle ready, WAIT with next-cycle rvalid, then EXEC with no stall.
- Each extra cycle of `imem_ready`=0, rvalid delay, or `stall`=1 adds one cycle.
- `exec_valid` rises the cycle after rvalid is captured and falls the cycle after retirement.
- `rst` has priority over every event, including `stall` and pending handshakes. An in-flight fetch is abandoned, and a later `imem_rvalid` for it is ignored because the FSM is not in WAIT.
- `pc_next` is sampled only on the retiring EXEC edge.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - At retirement, if `pc_next[1:0]`≠0, the PC is not updated and `retire_count` still increments.
  - `fault` is set and the FSM enters FAULT.
  - FAULT holds `imem_req`=0 and `exec_valid`=0 until `rst`.
- `FETCH_ALIGN_CHECK_EN` undefined: `pc` <= {`pc_next`[WORD_SIZE-1:2], 2'b00}, FAULT is unreachable, and `fault` is tied 0.

## Test plan
- Reset, zero-wait memory returning 0x012A4020 (add $t0,$t1,$t2), `pc_next`=pc+4:
  - First `imem_addr`=0x0 at cycle 1 after reset.
  - `exec_valid` is high for 1 cycle with opcode=0, rs=9, rt=10, rd=8, funct=0x20.
  - Next request goes to 0x4; `retire_count`=1.
- `imem_ready` low for 3 cycles: `imem_req` is held for 4 cycles with a constant address, and there is exactly one transition to WAIT.
- `stall` high for 5 cycles in EXEC: `exec_valid` stays high and fields stay constant for 6 cycles, with no PC change and no new request.
- `rst` asserted in WAIT, then a stale `imem_rvalid` arrives: it is ignored, `pc`=`RESET_VECTOR`, and `exec_valid` stays 0.
- `pc_next`=0x0000_1002 at retirement:
  - With the macro: `fault`=1, no further `imem_req`.
  - Without the macro: next `imem_addr`=0x0000_1000.
- `retire_count` preloaded near wrap via 2^32 retirements in a forced-state test, or a counter-force check: it wraps from 32'hFFFF_FFFF to 0.
